// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared types and constants for the irq_ctrl interrupt block.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0]  REG_ENABLE  = 2'd0;
    localparam logic [1:0]  REG_PENDING = 2'd1;
    localparam logic [1:0]  REG_EDGE    = 2'd2;
    localparam logic [1:0]  REG_CAUSE   = 2'd3;

    localparam logic [15:0] CAUSE_NONE  = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Lowest-index-wins priority encoder for active interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] active,
    output logic [3:0]         sel,
    output logic               valid
);

    always_comb begin
        sel = 4'd0;
        // Scan downwards so the lowest set index is the last one to win.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = 4'(i);
            end
        end
    end

    assign valid = |active;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt controller: sync, latch, mask, prioritise, ack/EOI.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src,
    input  logic               reg_wr,
    input  logic [1:0]         reg_addr,
    input  logic [15:0]        reg_wdata,
    output logic [15:0]        reg_rdata,
    output logic               irq,
    input  logic               irq_ack
);

    logic [NUM_SRC-1:0] r_s1, r_s2, r_s3;
    logic [NUM_SRC-1:0] r_enable, r_edge, r_pend;
    logic [15:0]        r_cause;
    logic               r_irq;
    state_t             r_state;

    logic [NUM_SRC-1:0] w_active, w_w1c, w_ack_clr, w_pend_nxt;
    logic [3:0]         w_sel;
    logic               w_valid, w_take;
    state_t             w_state_nxt;
    logic [15:0]        w_cause_nxt, w_rdata;
    logic               w_unused;

    assign w_active = r_pend & r_enable;

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .active (w_active),
        .sel    (w_sel),
        .valid  (w_valid)
    );

    assign w_take = (r_state == REQ) && irq_ack;
    assign w_w1c  = (reg_wr && reg_addr == REG_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0;

    always_comb begin
        w_ack_clr  = '0;
        w_pend_nxt = r_pend;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_clr[i] = w_take && w_valid && (w_sel == 4'(i));
            // A fresh edge beats a simultaneous clear so no event is lost.
            if (r_edge[i]) begin
                w_pend_nxt[i] = (r_s2[i] & ~r_s3[i]) |
                                (r_pend[i] & ~(w_w1c[i] | w_ack_clr[i]));
            end else begin
                w_pend_nxt[i] = r_s2[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            IDLE: begin
                if (w_valid) w_state_nxt = REQ;
            end
            REQ: begin
                if (irq_ack) begin
                    w_state_nxt = SERVICE;
                    w_cause_nxt = w_valid ? {12'd0, w_sel} : CAUSE_NONE;
                end else if (!w_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (reg_wr && reg_addr == REG_CAUSE) begin
                    w_state_nxt = IDLE;
                    w_cause_nxt = CAUSE_NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_enable <= '0;
            r_edge   <= '0;
            r_pend   <= '0;
            r_cause  <= CAUSE_NONE;
            r_irq    <= 1'b0;
            r_state  <= IDLE;
        end else begin
            r_s1    <= src;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_nxt;
            r_cause <= w_cause_nxt;
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == REQ);
            if (reg_wr && reg_addr == REG_ENABLE) r_enable <= reg_wdata[NUM_SRC-1:0];
            if (reg_wr && reg_addr == REG_EDGE)   r_edge   <= reg_wdata[NUM_SRC-1:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (reg_addr)
            REG_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
            REG_PENDING: w_rdata[NUM_SRC-1:0] = r_pend;
            REG_EDGE:    w_rdata[NUM_SRC-1:0] = r_edge;
            default:     w_rdata = r_cause;
        endcase
    end

    assign reg_rdata = w_rdata;
    assign irq       = r_irq;
    assign w_unused  = &{1'b0, reg_wdata};

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int NUM_SRC = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_SRC-1:0] src = '0;
    logic               reg_wr = 1'b0;
    logic [1:0]         reg_addr = 2'd0;
    logic [15:0]        reg_wdata = 16'd0;
    logic [15:0]        reg_rdata;
    logic               irq;
    logic               irq_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq       (irq),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_wr = 1'b0; reg_wdata = 16'd0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {15'd0, irq}, {15'd0, exp});
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        // Reset values
        step(); step();
        chk_irq("rst_irq", 1'b0);
        rd("rst_enable", 2'd0, 16'h0000);
        rd("rst_pending", 2'd1, 16'h0000);
        rd("rst_edge", 2'd2, 16'h0000);
        rd("rst_cause", 2'd3, 16'hFFFF);
        rst_n = 1'b1;
        step();

        // Single edge source, 3-edge latency
        wr(2'd0, 16'h0004);
        wr(2'd2, 16'h0004);
        rd("en_readback", 2'd0, 16'h0004);
        src = 8'h04;
        step();                       // sampling edge k
        src = 8'h00;
        chk_irq("lat_k", 1'b0);
        step(); chk_irq("lat_k1", 1'b0);
        step(); chk_irq("lat_k2", 1'b0);
        rd("lat_pend", 2'd1, 16'h0004);
        step(); chk_irq("lat_k3", 1'b1);
        ack();
        chk_irq("ack_irq_low", 1'b0);
        rd("ack_cause2", 2'd3, 16'h0002);
        rd("ack_pend_clr", 2'd1, 16'h0000);
        wr(2'd3, 16'h0000);
        rd("eoi_cause", 2'd3, 16'hFFFF);

        // Two simultaneous edges: priority then re-assert after EOI
        wr(2'd0, 16'h0022);
        wr(2'd2, 16'h0022);
        src = 8'h22;
        step(); step(); step();
        chk_irq("two_k2", 1'b0);
        step(); chk_irq("two_k3", 1'b1);
        ack();
        rd("two_cause1", 2'd3, 16'h0001);
        rd("two_pend5", 2'd1, 16'h0020);
        wr(2'd3, 16'h0000);
        chk_irq("two_eoi_low", 1'b0);
        rd("two_eoi_cause", 2'd3, 16'hFFFF);
        step(); chk_irq("two_reassert", 1'b1);
        ack();
        rd("two_cause5", 2'd3, 16'h0005);
        rd("two_pend_empty", 2'd1, 16'h0000);
        wr(2'd3, 16'h0000);
        src = 8'h00;
        step(); step(); step();

        // Level source
        wr(2'd2, 16'h0000);
        wr(2'd0, 16'h0001);
        step(); step(); step();
        src = 8'h01;
        step(); step(); step();
        chk_irq("lvl_k2", 1'b0);
        step(); chk_irq("lvl_k3", 1'b1);
        ack();
        rd("lvl_cause0", 2'd3, 16'h0000);
        rd("lvl_pend_kept", 2'd1, 16'h0001);
        wr(2'd3, 16'h0000);
        chk_irq("lvl_eoi_low", 1'b0);
        step(); chk_irq("lvl_reassert", 1'b1);
        src = 8'h00;
        step(); step(); step();
        chk_irq("lvl_drop_k2", 1'b1);
        step(); chk_irq("lvl_drop_k3", 1'b0);
        step(); chk_irq("lvl_idle", 1'b0);
        rd("lvl_cause_none", 2'd3, 16'hFFFF);

        // Masked edge, enable, W1C, and set-beats-clear
        wr(2'd0, 16'h0000);
        wr(2'd2, 16'h0008);
        src = 8'h08;
        step(); step(); step(); step();
        chk_irq("mask_irq", 1'b0);
        rd("mask_pend", 2'd1, 16'h0008);
        wr(2'd0, 16'h0008);
        chk_irq("en_k0", 1'b0);
        step(); chk_irq("en_k1", 1'b1);
        wr(2'd1, 16'h0008);
        rd("w1c_pend", 2'd1, 16'h0000);
        chk_irq("w1c_k0", 1'b1);
        step(); chk_irq("w1c_k1", 1'b0);
        src = 8'h00;
        step(); step(); step();
        src = 8'h08;
        step(); step();
        wr(2'd1, 16'h0008);             // W1C lands on the detect edge
        rd("setwin_pend", 2'd1, 16'h0008);
        chk_irq("setwin_k0", 1'b0);
        step(); chk_irq("setwin_k1", 1'b1);
        ack();
        rd("setwin_cause3", 2'd3, 16'h0003);
        wr(2'd3, 16'h0000);
        rd("setwin_eoi", 2'd3, 16'hFFFF);

        // Stray ack and EOI in IDLE
        ack();
        chk_irq("idle_ack_irq", 1'b0);
        rd("idle_ack_cause", 2'd3, 16'hFFFF);
        wr(2'd3, 16'h1234);
        chk_irq("idle_eoi_irq", 1'b0);
        rd("idle_eoi_cause", 2'd3, 16'hFFFF);
        step(); chk_irq("idle_still", 1'b0);

        // Asynchronous reset while in SERVICE
        src = 8'h00;
        step(); step(); step();
        src = 8'h08;
        step(); step(); step(); step();
        chk_irq("svc_req", 1'b1);
        ack();
        rd("svc_cause3", 2'd3, 16'h0003);
        rst_n = 1'b0;
        #1;
        chk_irq("arst_irq", 1'b0);
        rd("arst_enable", 2'd0, 16'h0000);
        rd("arst_pending", 2'd1, 16'h0000);
        rd("arst_edge", 2'd2, 16'h0000);
        rd("arst_cause", 2'd3, 16'hFFFF);
        #2;
        rst_n = 1'b1;
        src = 8'h00;
        step(); step();
        chk_irq("post_rst_irq", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
